// File: rtl/vga_1bit_pkg.sv
// Shared definitions for the 1-bit video capture path: register map,
// STATUS bit positions and the capture FSM state encoding.
package vga_1bit_pkg;

    localparam logic [2:0] REG_CONTROL = 3'd0;
    localparam logic [2:0] REG_S_ADDR  = 3'd1;
    localparam logic [2:0] REG_LENGTH  = 3'd2;
    localparam logic [2:0] REG_START   = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_OVERFLOW = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/vga_1bit_capture_fifo.sv
// 16-bit synchronous word FIFO with first-word-fall-through head and flush.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module capture_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        push,
    input  logic [15:0] din,
    input  logic        pop,
    output logic [15:0] head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vga_1bit_capture.sv
// Captures a 1-bit-per-pixel video stream, packs 16 pixels per word and
// writes the words to memory through an Avalon-MM write master.
module vga_1bit_capture
    import vga_1bit_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              avs_s1_chipselect,
    input  logic [2:0]        avs_s1_address,
    input  logic              avs_s1_read,
    input  logic              avs_s1_write,
    input  logic [31:0]       avs_s1_writedata,
    output logic [31:0]       avs_s1_readdata,
    output logic              avs_s1_irq,
    output logic [ADDR_W-1:0] avm_write_address,
    output logic              avm_write_write,
    output logic [15:0]       avm_write_writedata,
    input  logic              avm_write_waitrequest,
    input  logic              vid_vs,
    input  logic              vid_de,
    input  logic              vid_pix_en,
    input  logic              vid_pix
);

    state_t state, state_nx;

    logic              irq_en, cont, done, overflow;
    logic [31:0]       s_addr;
    logic [15:0]       length;
    logic [ADDR_W-1:0] addr_cnt;
    logic [15:0]       rem_cnt;
    logic [15:0]       push_cnt;
    logic              abort_pend, abort_pend_nx;
    logic              vs_q, vs_fall;
    logic [3:0]        bit_cnt;
    logic [15:0]       shreg, word;
    logic              word_vld;

    logic        reg_wr, start_wr, stop_wr;
    logic        load, frame_done, flush;
    logic        pix_ok, push_req, drop, fifo_push, xfer, stall;
    logic        fifo_full, fifo_empty;
    logic [15:0] fifo_head;
    logic [31:0] rd_mux;

    assign reg_wr   = avs_s1_chipselect & avs_s1_write;
    assign start_wr = reg_wr & (avs_s1_address == REG_START) &  avs_s1_writedata[0];
    assign stop_wr  = reg_wr & (avs_s1_address == REG_START) & ~avs_s1_writedata[0];

    assign vs_fall   = vs_q & ~vid_vs;
    assign pix_ok    = (state == CAPTURE) & vid_pix_en & vid_de & vid_vs;
    assign push_req  = word_vld & (state == CAPTURE);
    assign xfer      = avm_write_write & ~avm_write_waitrequest;
    assign stall     = avm_write_write &  avm_write_waitrequest;
    // A word arriving at a full FIFO survives only if a pop frees a slot this cycle.
    assign drop      = push_req & fifo_full & ~xfer & ~flush;
    assign fifo_push = push_req & ~drop;

    assign avm_write_write     = ~fifo_empty & ((state == CAPTURE) | (state == DRAIN));
    assign avm_write_address   = addr_cnt;
    assign avm_write_writedata = avm_write_write ? fifo_head : 16'h0000;
    assign avs_s1_irq          = done & irq_en;

    capture_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (fifo_push),
        .din     (word),
        .pop     (xfer),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_nx;
            abort_pend <= abort_pend_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        load          = 1'b0;
        frame_done    = 1'b0;
        flush         = 1'b0;
        abort_pend_nx = abort_pend;
        unique case (state)
            IDLE: begin
                abort_pend_nx = 1'b0;
                if (start_wr) begin
                    if (length == 16'd0) begin
                        frame_done = 1'b1;
                    end else begin
                        load     = 1'b1;
                        state_nx = WAIT_VS;
                    end
                end
            end
            WAIT_VS: if (vs_fall) state_nx = CAPTURE;
            CAPTURE: if (push_req && ({1'b0, push_cnt} + 17'd1 == {1'b0, length})) state_nx = DRAIN;
            DRAIN: begin
                if (rem_cnt == 16'd0) begin
                    frame_done = 1'b1;
                    if (cont) begin
                        load     = 1'b1;
                        state_nx = WAIT_VS;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // Abort waits out a stalled transfer so the bus sees a clean handshake.
        if (state != IDLE && (stop_wr || abort_pend)) begin
            state_nx   = state;
            load       = 1'b0;
            frame_done = 1'b0;
            if (stall) begin
                abort_pend_nx = 1'b1;
            end else begin
                abort_pend_nx = 1'b0;
                flush         = 1'b1;
                state_nx      = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en   <= 1'b0;
            cont     <= 1'b0;
            s_addr   <= '0;
            length   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (reg_wr) begin
                unique case (avs_s1_address)
                    REG_CONTROL: begin
                        irq_en <= avs_s1_writedata[0];
                        cont   <= avs_s1_writedata[1];
                    end
                    REG_S_ADDR: s_addr <= avs_s1_writedata;
                    REG_LENGTH: length <= avs_s1_writedata[15:0];
                    REG_STATUS: begin
                        if (avs_s1_writedata[STAT_DONE])     done     <= 1'b0;
                        if (avs_s1_writedata[STAT_OVERFLOW]) overflow <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (frame_done) done     <= 1'b1;
            if (drop)       overflow <= 1'b1;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        unique case (avs_s1_address)
            REG_CONTROL: rd_mux = {30'd0, cont, irq_en};
            REG_S_ADDR:  rd_mux = s_addr;
            REG_LENGTH:  rd_mux = {16'd0, length};
            REG_STATUS:  rd_mux = {29'd0, overflow, done, state != IDLE};
            default:     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) avs_s1_readdata <= 32'd0;
        else          avs_s1_readdata <= (avs_s1_chipselect & avs_s1_read) ? rd_mux : 32'd0;
    end

    // Dropped words count as pushed and retire from rem_cnt without moving the address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_cnt <= '0;
            rem_cnt  <= '0;
            push_cnt <= '0;
        end else if (load) begin
            addr_cnt <= ADDR_W'(s_addr);
            rem_cnt  <= length;
            push_cnt <= '0;
        end else begin
            if (xfer)     addr_cnt <= addr_cnt + ADDR_W'(2);
            if (push_req) push_cnt <= push_cnt + 16'd1;
            rem_cnt <= rem_cnt - 16'(xfer) - 16'(drop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q     <= 1'b0;
            bit_cnt  <= '0;
            word_vld <= 1'b0;
        end else begin
            vs_q     <= vid_vs;
            word_vld <= 1'b0;
            if (state != CAPTURE || vs_fall) begin
                bit_cnt <= '0;
            end else if (pix_ok) begin
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd15) word_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pix_ok) begin
            shreg <= {shreg[14:0], vid_pix};
            if (bit_cnt == 4'd15) word <= {shreg[14:0], vid_pix};
        end
    end

endmodule

// File: tb/tb_vga_1bit_capture.sv
// Directed bench for vga_1bit_capture: register access, frame capture,
// bus stalls, overflow, zero length, abort and continuous mode.
module tb_vga_1bit_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs, rd, wr;
    logic [2:0]  adr;
    logic [31:0] wdata;
    logic [31:0] readdata;
    logic        irq;
    logic [31:0] m_addr;
    logic        m_write;
    logic [15:0] m_data;
    logic        wreq = 1'b0;
    logic        vs, de, pen, pix;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic        force_wreq = 1'b0;
    int          stall_req_idx = -1;
    int          stall_used_idx = -1;
    int          stall_left = 0;
    logic        stall_wreq = 1'b0;

    logic [31:0] log_addr [$];
    logic [15:0] log_data [$];
    int          stall_seen = 0;
    int          stall_viol = 0;
    int          write_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [15:0] prev_data;

    vga_1bit_capture #(.FIFO_DEPTH(8), .ADDR_W(32)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .avs_s1_chipselect     (cs),
        .avs_s1_address        (adr),
        .avs_s1_read           (rd),
        .avs_s1_write          (wr),
        .avs_s1_writedata      (wdata),
        .avs_s1_readdata       (readdata),
        .avs_s1_irq            (irq),
        .avm_write_address     (m_addr),
        .avm_write_write       (m_write),
        .avm_write_writedata   (m_data),
        .avm_write_waitrequest (wreq),
        .vid_vs                (vs),
        .vid_de                (de),
        .vid_pix_en            (pen),
        .vid_pix               (pix)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Waitrequest driver: forced stall, or a one-shot 5-cycle stall on a given write index.
    always @(posedge clk) begin
        #1;
        if (stall_req_idx >= 0 && stall_req_idx != stall_used_idx && m_write === 1'b1 &&
            log_addr.size() == stall_req_idx) begin
            stall_used_idx = stall_req_idx;
            stall_left = 4;
            stall_wreq = 1'b1;
        end else if (stall_left > 0) begin
            stall_left--;
        end else begin
            stall_wreq = 1'b0;
        end
        wreq = force_wreq | stall_wreq;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall && (m_write !== 1'b1 || m_addr !== prev_addr || m_data !== prev_data))
                stall_viol++;
            if (m_write === 1'b1) write_seen++;
            if (m_write === 1'b1 && wreq) stall_seen++;
            if (m_write === 1'b1 && !wreq) begin
                log_addr.push_back(m_addr);
                log_data.push_back(m_data);
            end
            prev_stall = (m_write === 1'b1) && wreq;
            prev_addr  = m_addr;
            prev_data  = m_data;
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; adr = a; wdata = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; adr = a;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        vs = 1'b0;
        @(posedge clk); #1;
        vs = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            pen = 1'b1; de = 1'b1; pix = w[i];
            @(posedge clk); #1;
        end
        pen = 1'b0; de = 1'b0; pix = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] s);
        int n;
        s = 32'd0;
        n = 0;
        while (s[1] !== 1'b1 && n < 600) begin
            bus_read(3'd4, s);
            n++;
        end
        checks++;
        if (s[1] !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout: status=%0h after %0d reads, done bit required", s, n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] s;
        reset_n = 1'b0;
        cs = 0; rd = 0; wr = 0; adr = 0; wdata = 0;
        vs = 1'b1; de = 0; pen = 0; pix = 0;
        #23;
        checks++; if (readdata !== 32'd0) begin failures++; $display("FAIL rst_readdata: got %0h want 0", readdata); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq: got %0b want 0", irq); end
        checks++; if (m_write !== 1'b0) begin failures++; $display("FAIL rst_write: got %0b want 0", m_write); end
        checks++; if (m_addr !== 32'd0) begin failures++; $display("FAIL rst_addr: got %0h want 0", m_addr); end
        checks++; if (m_data !== 16'd0) begin failures++; $display("FAIL rst_data: got %0h want 0", m_data); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        bus_read(3'd4, s);
        checks++; if (s !== 32'd0) begin failures++; $display("FAIL rst_status: got %0h want 0", s); end
        bus_read(3'd0, s);
        checks++; if (s !== 32'd0) begin failures++; $display("FAIL rst_control: got %0h want 0", s); end
    endtask

    task automatic test_basic();
        logic [31:0] s;
        int base;
        base = log_addr.size();
        bus_write(3'd1, 32'h0090_0000);
        bus_write(3'd2, 32'd4);
        bus_write(3'd0, 32'd1);
        bus_read(3'd2, s);
        checks++; if (s !== 32'd4) begin failures++; $display("FAIL length_readback: got %0h want 4", s); end
        bus_write(3'd3, 32'd1);
        vs_pulse();
        repeat (4) send_word(16'hAAAA);
        wait_done(s);
        checks++; if (s !== 32'h2) begin failures++; $display("FAIL basic_status: got %0h want 2", s); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL basic_irq: got %0b want 1", irq); end
        checks++; if (log_addr.size() - base !== 4) begin failures++; $display("FAIL basic_count: got %0d want 4", log_addr.size() - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_addr[base+k] !== 32'h0090_0000 + 32'(2*k) || log_data[base+k] !== 16'hAAAA) begin
                failures++;
                $display("FAIL basic_word%0d: got %0h@%0h want aaaa@%0h", k, log_data[base+k], log_addr[base+k], 32'h0090_0000 + 32'(2*k));
            end
        end
        bus_write(3'd4, 32'h2);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %0b want 0", irq); end
    endtask

    task automatic test_stall();
        logic [31:0] s;
        logic [15:0] w [4];
        int base, sv0, ss0;
        w[0] = 16'h0001; w[1] = 16'h8000; w[2] = 16'h7FFE; w[3] = 16'hFFFF;
        base = log_addr.size();
        sv0 = stall_viol; ss0 = stall_seen;
        stall_req_idx = base + 1;
        bus_write(3'd3, 32'd1);
        vs_pulse();
        for (int k = 0; k < 4; k++) send_word(w[k]);
        wait_done(s);
        checks++; if (s !== 32'h2) begin failures++; $display("FAIL stall_status: got %0h want 2", s); end
        checks++; if (stall_seen - ss0 !== 5) begin failures++; $display("FAIL stall_cycles: got %0d want 5", stall_seen - ss0); end
        checks++; if (stall_viol !== sv0) begin failures++; $display("FAIL stall_stable: got %0d violations want 0", stall_viol - sv0); end
        checks++; if (log_addr.size() - base !== 4) begin failures++; $display("FAIL stall_count: got %0d want 4", log_addr.size() - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_addr[base+k] !== 32'h0090_0000 + 32'(2*k) || log_data[base+k] !== w[k]) begin
                failures++;
                $display("FAIL stall_word%0d: got %0h@%0h want %0h@%0h", k, log_data[base+k], log_addr[base+k], w[k], 32'h0090_0000 + 32'(2*k));
            end
        end
        bus_write(3'd4, 32'h2);
    endtask

    task automatic test_overflow();
        logic [31:0] s;
        int base, t0;
        base = log_addr.size();
        bus_write(3'd1, 32'h0000_1000);
        bus_write(3'd2, 32'd20);
        force_wreq = 1'b1;
        t0 = cyc;
        bus_write(3'd3, 32'd1);
        vs_pulse();
        for (int k = 0; k < 20; k++) send_word(16'hC300 + 16'(k));
        while (cyc - t0 < 400) @(posedge clk);
        #1;
        checks++; if (log_addr.size() !== base) begin failures++; $display("FAIL ovf_no_write: got %0d writes want 0", log_addr.size() - base); end
        force_wreq = 1'b0;
        wait_done(s);
        checks++; if (s !== 32'h6) begin failures++; $display("FAIL ovf_status: got %0h want 6", s); end
        checks++; if (log_addr.size() - base !== 8) begin failures++; $display("FAIL ovf_count: got %0d want 8", log_addr.size() - base); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (log_addr[base+k] !== 32'h1000 + 32'(2*k) || log_data[base+k] !== 16'hC300 + 16'(k)) begin
                failures++;
                $display("FAIL ovf_word%0d: got %0h@%0h want %0h@%0h", k, log_data[base+k], log_addr[base+k], 16'hC300 + 16'(k), 32'h1000 + 32'(2*k));
            end
        end
        bus_write(3'd4, 32'h6);
        bus_read(3'd4, s);
        checks++; if (s !== 32'h0) begin failures++; $display("FAIL w1c_clear: got %0h want 0", s); end
    endtask

    task automatic test_length_zero();
        logic [31:0] s;
        int ws0;
        ws0 = write_seen;
        bus_write(3'd2, 32'd0);
        bus_write(3'd3, 32'd1);
        bus_read(3'd4, s);
        checks++; if (s !== 32'h2) begin failures++; $display("FAIL len0_status: got %0h want 2", s); end
        idle(10);
        checks++; if (write_seen !== ws0) begin failures++; $display("FAIL len0_nowrite: got %0d write cycles want 0", write_seen - ws0); end
        bus_write(3'd4, 32'h2);
    endtask

    task automatic test_abort();
        logic [31:0] s;
        int base;
        base = log_addr.size();
        bus_write(3'd1, 32'h0000_2000);
        bus_write(3'd2, 32'd4);
        force_wreq = 1'b1;
        bus_write(3'd3, 32'd1);
        vs_pulse();
        send_word(16'h1234);
        send_word(16'h5678);
        bus_write(3'd3, 32'd0);
        idle(5);
        bus_read(3'd4, s);
        checks++; if (s !== 32'h1) begin failures++; $display("FAIL abort_busy: got %0h want 1", s); end
        checks++; if (m_addr !== 32'h2000 || m_write !== 1'b1) begin failures++; $display("FAIL abort_hold: got write=%0b addr=%0h want 1/2000", m_write, m_addr); end
        force_wreq = 1'b0;
        idle(5);
        bus_read(3'd4, s);
        checks++; if (s !== 32'h0) begin failures++; $display("FAIL abort_status: got %0h want 0", s); end
        checks++; if (m_write !== 1'b0) begin failures++; $display("FAIL abort_flush: got write=%0b want 0", m_write); end
        idle(20);
        checks++; if (log_addr.size() - base !== 1) begin failures++; $display("FAIL abort_count: got %0d want 1", log_addr.size() - base); end
        checks++;
        if (log_addr.size() > base && (log_addr[base] !== 32'h2000 || log_data[base] !== 16'h1234)) begin
            failures++;
            $display("FAIL abort_word: got %0h@%0h want 1234@2000", log_data[base], log_addr[base]);
        end
    endtask

    task automatic test_continuous();
        logic [31:0] s;
        logic [15:0] w [4];
        int base;
        w[0] = 16'h0F0F; w[1] = 16'hF0F0; w[2] = 16'h1111; w[3] = 16'h2222;
        base = log_addr.size();
        bus_write(3'd0, 32'd3);
        bus_write(3'd1, 32'h0000_3000);
        bus_write(3'd2, 32'd2);
        bus_write(3'd3, 32'd1);
        vs_pulse();
        send_word(w[0]);
        send_word(w[1]);
        wait_done(s);
        checks++; if (s !== 32'h3) begin failures++; $display("FAIL cont_status1: got %0h want 3", s); end
        bus_write(3'd4, 32'h2);
        vs_pulse();
        send_word(w[2]);
        send_word(w[3]);
        wait_done(s);
        checks++; if (s !== 32'h3) begin failures++; $display("FAIL cont_status2: got %0h want 3", s); end
        checks++; if (log_addr.size() - base !== 4) begin failures++; $display("FAIL cont_count: got %0d want 4", log_addr.size() - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_addr[base+k] !== 32'h3000 + 32'(2*(k%2)) || log_data[base+k] !== w[k]) begin
                failures++;
                $display("FAIL cont_word%0d: got %0h@%0h want %0h@%0h", k, log_data[base+k], log_addr[base+k], w[k], 32'h3000 + 32'(2*(k%2)));
            end
        end
        bus_write(3'd3, 32'd0);
        bus_read(3'd4, s);
        checks++; if (s !== 32'h2) begin failures++; $display("FAIL cont_stop: got %0h want 2", s); end
        bus_write(3'd4, 32'h2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_length_zero();
        test_abort();
        test_continuous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
